// File: rtl/sdram_port_arbiter.sv
// Two-master arbiter for the 128-bit SDRAM bridge port: port 0 high priority, port 1 starvation-protected.
// Optional build macro SDRAM_ARB_TIMEOUT_EN adds an ISSUE abort timer that drives rN_error.
module sdram_port_arbiter #(
  parameter int ADDR_W   = 26,
  parameter int DATA_W   = 128,
  parameter int BE_W     = 16,
  parameter int MAX_WAIT = 8,
  parameter int TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic [BE_W-1:0]   r0_byte_enable,
  input  logic              r0_read,
  input  logic              r0_write,
  input  logic [DATA_W-1:0] r0_write_data,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_read_data,
  output logic              r0_error,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic [BE_W-1:0]   r1_byte_enable,
  input  logic              r1_read,
  input  logic              r1_write,
  input  logic [DATA_W-1:0] r1_write_data,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_read_data,
  output logic              r1_error,
  output logic [ADDR_W-1:0] m_address,
  output logic [BE_W-1:0]   m_byte_enable,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_write_data,
  input  logic              m_acknowledge,
  input  logic [DATA_W-1:0] m_read_data,
  output logic              busy,
  output logic              owner,
  output logic [1:0]        dbg_state
);
  // Handshake: rN_read/rN_write are held until the one-cycle rN_ack; m_read/m_write are held
  // until the one-cycle m_acknowledge, which counts only while in ISSUE.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_e;

  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] MAX_WAIT_C = SW'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [SW-1:0]     starve_q;
  logic              owner_q;
  logic [ADDR_W-1:0] m_address_q;
  logic [BE_W-1:0]   m_byte_enable_q;
  logic              m_read_q, m_write_q;
  logic [DATA_W-1:0] m_write_data_q;
  logic [DATA_W-1:0] r0_read_data_q, r1_read_data_q;
  logic              req0, req1, grant1, sel_rd, sel_wr;
  logic              tmo_hit;

  assign req0   = r0_read | r0_write;
  assign req1   = r1_read | r1_write;
  assign grant1 = req1 & (~req0 | (starve_q >= MAX_WAIT_C));
  assign sel_rd = grant1 ? r1_read : r0_read;
  assign sel_wr = grant1 ? r1_write : r0_write;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);
  logic [9:0] tmo_q;
  logic       err_q;

  assign tmo_hit = (state_q == ISSUE) && !m_acknowledge && (tmo_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    begin tmo_q <= '0; err_q <= 1'b0; end
        ISSUE:   begin tmo_q <= tmo_q + 10'd1; if (tmo_hit) err_q <= 1'b1; end
        default: ;
      endcase
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 | req1) state_d = ISSUE;
      ISSUE:   if (m_acknowledge | tmo_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    r0_ack    = (state_q == DONE) && !owner_q;
    r1_ack    = (state_q == DONE) && owner_q;
    r0_error  = 1'b0;
    r1_error  = 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
    r0_error  = r0_ack & err_q;
    r1_error  = r1_ack & err_q;
`endif
    dbg_state = state_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q        <= '0;
      owner_q         <= 1'b0;
      m_address_q     <= '0;
      m_byte_enable_q <= '0;
      m_read_q        <= 1'b0;
      m_write_q       <= 1'b0;
      m_write_data_q  <= '0;
      r0_read_data_q  <= '0;
      r1_read_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (req0 | req1) begin
          owner_q         <= grant1;
          m_address_q     <= grant1 ? r1_address : r0_address;
          m_byte_enable_q <= grant1 ? r1_byte_enable : r0_byte_enable;
          m_write_data_q  <= grant1 ? r1_write_data : r0_write_data;
          m_read_q        <= sel_rd;
          m_write_q       <= sel_wr & ~sel_rd;  // read wins when both strobes are set
          if (grant1)
            starve_q <= '0;
          else if (req1 && starve_q < MAX_WAIT_C)
            starve_q <= starve_q + 1'b1;
        end
        ISSUE: if (m_acknowledge) begin
          m_read_q  <= 1'b0;
          m_write_q <= 1'b0;
          if (m_read_q) begin
            if (owner_q) r1_read_data_q <= m_read_data;
            else         r0_read_data_q <= m_read_data;
          end
        end else if (tmo_hit) begin
          m_read_q  <= 1'b0;
          m_write_q <= 1'b0;
          if (owner_q) r1_read_data_q <= '0;
          else         r0_read_data_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign owner         = owner_q;
  assign m_address     = m_address_q;
  assign m_byte_enable = m_byte_enable_q;
  assign m_read        = m_read_q;
  assign m_write       = m_write_q;
  assign m_write_data  = m_write_data_q;
  assign r0_read_data  = r0_read_data_q;
  assign r1_read_data  = r1_read_data_q;
endmodule
